// File: rtl/apb4_pkg.sv
// Shared APB4 definitions for the requester (bridge) and completer-side stages.
package apb4_pkg;

    // Transfer phase of an APB4 requester
    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_t;

    // Bit positions inside pprot
    localparam int PROT_PRIV   = 0;
    localparam int PROT_NONSEC = 1;
    localparam int PROT_INSTR  = 2;

    // Counter width able to hold 0..timeout; never narrower than one bit
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb4_timeout_counter.sv
// Counts ACCESS cycles spent waiting for pready; flags the last permitted cycle.
module apb4_timeout_counter
    import apb4_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic pclk,
    input  logic presetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = cnt_width(TIMEOUT);
    // Count value seen during the TIMEOUT-th waiting cycle
    localparam logic [CNT_W-1:0] LAST_CNT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_r;
    logic             expired_s;

    // Expiry is reported during the cycle that would be the TIMEOUT-th wait, so
    // the requester aborts on that cycle's closing edge; TIMEOUT=0 never expires.
    always_comb begin
        expired_s = 1'b0;
        if ((TIMEOUT != 0) && enable && (count_r == LAST_CNT)) begin
            expired_s = 1'b1;
        end else begin
            expired_s = 1'b0;
        end
    end

    assign expired = expired_s;

    // Wait-cycle counter: cleared each SETUP, advances on every stalled ACCESS cycle
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && !expired_s) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/apb4_master_bridge.sv
// Valid/ready command to APB4 transfer bridge with a single outstanding transfer,
// registered APB outputs, a held response channel and a pready timeout.
module apb4_master_bridge
    import apb4_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int STRB_W  = DATA_W / 8,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_strb,
    input  logic [2:0]        cmd_prot,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    output logic [DATA_W-1:0] pwdata,
    output logic [STRB_W-1:0] pstrb,
    output logic [2:0]        pprot,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    apb_state_t        state_r,   state_s;
    logic [ADDR_W-1:0] paddr_r,   paddr_s;
    logic              pwrite_r,  pwrite_s;
    logic              psel_r,    psel_s;
    logic              penable_r, penable_s;
    logic [DATA_W-1:0] pwdata_r,  pwdata_s;
    logic [STRB_W-1:0] pstrb_r,   pstrb_s;
    logic [2:0]        pprot_r,   pprot_s;
    logic              rsp_valid_r,   rsp_valid_s;
    logic [DATA_W-1:0] rsp_rdata_r,   rsp_rdata_s;
    logic              rsp_err_r,     rsp_err_s;
    logic              rsp_timeout_r, rsp_timeout_s;
    logic              cmd_ready_s;
    logic              expired_s;

    // Only idle with no response pending may take a command; no overlap of response and transfer
    assign cmd_ready_s = (state_r == APB_IDLE) && !rsp_valid_r;

    apb4_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .pclk    (pclk),
        .presetn (presetn),
        .clear   (state_r == APB_SETUP),
        .enable  ((state_r == APB_ACCESS) && !pready),
        .expired (expired_s)
    );

    // Next state and next values of every registered output
    always_comb begin
        state_s       = state_r;
        paddr_s       = paddr_r;
        pwrite_s      = pwrite_r;
        psel_s        = psel_r;
        penable_s     = penable_r;
        pwdata_s      = pwdata_r;
        pstrb_s       = pstrb_r;
        pprot_s       = pprot_r;
        rsp_valid_s   = rsp_valid_r;
        rsp_rdata_s   = rsp_rdata_r;
        rsp_err_s     = rsp_err_r;
        rsp_timeout_s = rsp_timeout_r;

        if (rsp_valid_r && rsp_ready) begin
            rsp_valid_s = 1'b0;
        end else begin
            rsp_valid_s = rsp_valid_r;
        end

        case (state_r)
            APB_IDLE: begin
                if (cmd_valid && cmd_ready_s) begin
                    state_s   = APB_SETUP;
                    paddr_s   = cmd_addr;
                    pwrite_s  = cmd_write;
                    pprot_s   = cmd_prot;
                    // Reads drive zero data and strobes
                    pwdata_s  = cmd_write ? cmd_wdata : '0;
                    pstrb_s   = cmd_write ? cmd_strb  : '0;
                    psel_s    = 1'b1;
                    penable_s = 1'b0;
                end else begin
                    state_s = APB_IDLE;
                end
            end
            APB_SETUP: begin
                state_s   = APB_ACCESS;
                penable_s = 1'b1;
            end
            APB_ACCESS: begin
                if (pready) begin
                    state_s       = APB_IDLE;
                    psel_s        = 1'b0;
                    penable_s     = 1'b0;
                    rsp_valid_s   = 1'b1;
                    rsp_rdata_s   = pwrite_r ? '0 : prdata;
                    rsp_err_s     = pslverr;
                    rsp_timeout_s = 1'b0;
                end else if (expired_s) begin
                    state_s       = APB_IDLE;
                    psel_s        = 1'b0;
                    penable_s     = 1'b0;
                    rsp_valid_s   = 1'b1;
                    rsp_rdata_s   = '0;
                    rsp_err_s     = 1'b1;
                    rsp_timeout_s = 1'b1;
                end else begin
                    state_s = APB_ACCESS;
                end
            end
            default: begin
                state_s   = APB_IDLE;
                psel_s    = 1'b0;
                penable_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops an in-flight transfer and any pending response
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_r       <= APB_IDLE;
            paddr_r       <= '0;
            pwrite_r      <= 1'b0;
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            pwdata_r      <= '0;
            pstrb_r       <= '0;
            pprot_r       <= 3'b000;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= '0;
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            paddr_r       <= paddr_s;
            pwrite_r      <= pwrite_s;
            psel_r        <= psel_s;
            penable_r     <= penable_s;
            pwdata_r      <= pwdata_s;
            pstrb_r       <= pstrb_s;
            pprot_r       <= pprot_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_rdata_r   <= rsp_rdata_s;
            rsp_err_r     <= rsp_err_s;
            rsp_timeout_r <= rsp_timeout_s;
        end
    end

    assign cmd_ready   = cmd_ready_s;
    assign paddr       = paddr_r;
    assign pwrite      = pwrite_r;
    assign psel        = psel_r;
    assign penable     = penable_r;
    assign pwdata      = pwdata_r;
    assign pstrb       = pstrb_r;
    assign pprot       = pprot_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_err     = rsp_err_r;
    assign rsp_timeout = rsp_timeout_r;

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Self-checking bench for apb4_master_bridge: directed scenarios plus random
// transfers against a small memory-backed completer and a reference memory.
module tb_apb4_master_bridge;
    import apb4_pkg::*;

    localparam int TO = 16;

    logic        pclk;
    logic        presetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic [1:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [15:0] paddr;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [15:0] pwdata;
    logic [1:0]  pstrb;
    logic [2:0]  pprot;
    logic [15:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_cmp  = 0;
    int n_fail = 0;

    // Completer storage (written from DUT bus values) and reference storage (written from commands)
    logic [15:0] slave_mem [16];
    logic [15:0] ref_mem   [16];

    apb4_master_bridge #(
        .ADDR_W (16), .DATA_W (16), .STRB_W (2), .TIMEOUT (TO)
    ) dut (
        .pclk (pclk), .presetn (presetn),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
        .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata), .cmd_strb (cmd_strb), .cmd_prot (cmd_prot),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_rdata (rsp_rdata),
        .rsp_err (rsp_err), .rsp_timeout (rsp_timeout),
        .paddr (paddr), .pwrite (pwrite), .psel (psel), .penable (penable),
        .pwdata (pwdata), .pstrb (pstrb), .pprot (pprot),
        .prdata (prdata), .pready (pready), .pslverr (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                          input logic [1:0] strb);
        logic [15:0] r;
        r = old;
        for (int b = 0; b < 2; b++) begin
            if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    // One complete command/transfer/response exchange with full protocol checking
    task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [1:0] strb, input logic [2:0] prot, input int waits,
                           input logic serr, input logic hang, input int hold);
        int          cyc, acc, setup, exp_acc;
        logic        done;
        logic [15:0] exp_rd, held_rd;
        logic        held_err, held_to;

        exp_rd  = (wr || hang) ? 16'h0000 : ref_mem[addr[3:0]];
        exp_acc = hang ? TO : waits + 1;

        @(negedge pclk);
        check("cmd_ready_before_accept", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
        cmd_wdata = wdata; cmd_strb = strb; cmd_prot = prot;
        @(posedge pclk);
        #1;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom); cmd_addr = 16'($urandom);
        cmd_wdata = 16'($urandom); cmd_strb = 2'($urandom); cmd_prot = 3'($urandom);

        cyc = 0; acc = 0; setup = 0; done = 1'b0;
        while (!done && cyc < 64) begin
            @(negedge pclk);
            cyc++;
            if (rsp_valid) begin
                done = 1'b1;
                pready = 1'b0; pslverr = 1'b0;
            end else if (psel) begin
                if (!penable) setup++;
                else acc++;
                check("apb_paddr",  paddr,  addr);
                check("apb_pwrite", pwrite, wr);
                check("apb_pprot",  pprot,  prot);
                check("apb_pwdata", pwdata, wr ? wdata : 16'h0000);
                check("apb_pstrb",  pstrb,  wr ? strb : 2'b00);
                if (penable) begin
                    pready  = !hang && (acc == waits + 1);
                    prdata  = pready ? slave_mem[paddr[3:0]] : 16'($urandom);
                    pslverr = pready ? serr : 1'($urandom);
                    if (pready && pwrite && !serr)
                        slave_mem[paddr[3:0]] = merge(slave_mem[paddr[3:0]], pwdata, pstrb);
                end else begin
                    pready = 1'($urandom); pslverr = 1'($urandom);
                end
            end else begin
                pready = 1'b0; pslverr = 1'b0;
            end
        end
        pready = 1'b0; pslverr = 1'b0;

        check("rsp_seen",        done, 1);
        check("rsp_latency",     cyc, exp_acc + 2);
        check("setup_cycles",    setup, 1);
        check("access_cycles",   acc, exp_acc);
        check("psel_at_rsp",     psel, 0);
        check("penable_at_rsp",  penable, 0);
        check("rsp_rdata",       rsp_rdata, exp_rd);
        check("rsp_err",         rsp_err, serr || hang);
        check("rsp_timeout",     rsp_timeout, hang);
        check("cmd_ready_busy",  cmd_ready, 0);

        if (wr && !serr && !hang) ref_mem[addr[3:0]] = merge(ref_mem[addr[3:0]], wdata, strb);

        // Back-pressure the response while a new command is offered
        held_rd = rsp_rdata; held_err = rsp_err; held_to = rsp_timeout;
        rsp_ready = 1'b0;
        cmd_valid = (hold > 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge pclk);
            check("hold_cmd_ready", cmd_ready, 0);
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rsp_rdata", rsp_rdata, held_rd);
            check("hold_rsp_err",   {rsp_err, rsp_timeout}, {held_err, held_to});
            check("hold_psel",      psel, 0);
        end
        cmd_valid = 1'b0;

        rsp_ready = 1'b1;
        @(posedge pclk);
        #1;
        rsp_ready = 1'b0;
        @(negedge pclk);
        check("rsp_valid_cleared", rsp_valid, 0);
        check("cmd_ready_after",   cmd_ready, 1);
        check("psel_after",        psel, 0);
    endtask

    initial begin
        presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'h0000;
        cmd_wdata = 16'h0000; cmd_strb = 2'b00; cmd_prot = 3'b000; rsp_ready = 1'b0;
        prdata = 16'h0000; pready = 1'b0; pslverr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            slave_mem[i] = 16'(i * 16'h1111);
            ref_mem[i]   = 16'(i * 16'h1111);
        end

        // Reset state
        #1;
        check("rst_psel",      psel, 0);
        check("rst_penable",   penable, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_flags", {rsp_err, rsp_timeout, pwrite}, 3'b000);
        check("rst_paddr",     paddr, 0);
        check("rst_pwdata",    pwdata, 0);
        check("rst_pstrb_prot", {pstrb, pprot}, 5'b00000);
        check("rst_rsp_rdata", rsp_rdata, 0);
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        presetn = 1'b1;

        // Zero-wait write
        run_txn(1'b1, 16'h00A0, 16'h1234, 2'b11, 3'(1 << PROT_PRIV), 0, 1'b0, 1'b0, 0);
        // Read with three wait states from a completer holding 0xBEEF
        slave_mem[0] = 16'hBEEF; ref_mem[0] = 16'hBEEF;
        run_txn(1'b0, 16'h00A0, 16'h5555, 2'b11, 3'(1 << PROT_NONSEC), 3, 1'b0, 1'b0, 0);
        // Write answered with pslverr, then a normal command
        run_txn(1'b1, 16'h0003, 16'hCAFE, 2'b01, 3'(1 << PROT_INSTR), 1, 1'b1, 1'b0, 0);
        run_txn(1'b0, 16'h0003, 16'h0000, 2'b00, 3'b000, 0, 1'b0, 1'b0, 0);
        // Hung completer times out; response held for 10 cycles with a command waiting
        run_txn(1'b0, 16'h0007, 16'h0000, 2'b00, 3'b111, 0, 1'b0, 1'b1, 10);

        // Random traffic
        for (int t = 0; t < 40; t++) begin
            run_txn(1'($urandom), {12'h000, 4'($urandom)}, 16'($urandom), 2'($urandom),
                    3'($urandom), int'($urandom_range(0, 4)), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 9) == 0), int'($urandom_range(0, 3)));
        end

        // Reset during ACCESS
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0005;
        cmd_wdata = 16'hA5A5; cmd_strb = 2'b11; cmd_prot = 3'b010;
        @(posedge pclk);
        #1;
        cmd_valid = 1'b0; pready = 1'b0;
        repeat (3) @(negedge pclk);
        check("pre_rst_penable", penable, 1);
        #2;
        presetn = 1'b0;
        #1;
        check("midrst_psel",      psel, 0);
        check("midrst_penable",   penable, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_paddr",     paddr, 0);
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        presetn = 1'b1;
        run_txn(1'b0, 16'h0005, 16'h0000, 2'b00, 3'b001, 2, 1'b0, 1'b0, 0);
        run_txn(1'b1, 16'h0005, 16'h0F0F, 2'b10, 3'b000, 0, 1'b0, 1'b0, 1);
        run_txn(1'b0, 16'h0005, 16'h0000, 2'b00, 3'b000, 1, 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
